// File: rtl/fa_arith_pkg.sv
// Shared arithmetic-unit definitions for the signed divider.
// Holds the divider state encoding and default sizing constants.
package fa_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 4;
    localparam int MIN_NEG   = 1 << (DIV_WIDTH - 1);
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // Counter width for an arbitrary operand width (at least one bit).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_divss2_step.sv
// One restoring shift-subtract iteration of the signed divider.
// Purely combinational: (prem, quo, divisor) -> (prem_next, quo_next).
module fa_divss2_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   prem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH:0]   dvs_i,
    output logic [WIDTH:0]   prem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] trial;
    logic             neg;
    logic             unused_prem_msb;

    // The partial remainder is always below the divisor, so its top bit
    // is zero on entry and drops out of the shifted value.
    assign unused_prem_msb = prem_i[WIDTH];

    // Shift in the next dividend bit, trial-subtract, restore on borrow.
    always_comb begin
        sh     = {prem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        trial  = {1'b0, sh} - {1'b0, dvs_i};
        neg    = trial[WIDTH+1];
        prem_o = neg ? sh : trial[WIDTH:0];
        quo_o  = {quo_i[WIDTH-2:0], ~neg};
    end

endmodule

// File: rtl/fa_divss2.sv
// Sequential signed divider, restoring, one quotient bit per clock.
// Optional one-entry request buffer: define FA_DIVSS2_QUEUE_EN.
module fa_divss2
    import fa_arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] rem,
    output logic             ovf,
    output logic             dz
);

    localparam int LCNT_W = cnt_width(WIDTH);
    localparam logic [LCNT_W-1:0] LAST = LCNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  ONES = {WIDTH{1'b1}};

    div_state_e        state_q, state_d;
    logic [LCNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]    prem_q, prem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH:0]    dvs_q, dvs_d;
    logic              sgnq_q, sgnq_d;
    logic              sgnr_q, sgnr_d;
    logic              ovfp_q, ovfp_d;
    logic              dzp_q, dzp_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              ovf_q, ovf_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;

    logic              launch;
    logic [WIDTH-1:0]  lx, ly;
    logic [WIDTH:0]    lx_ext, ly_ext, ax, ay;
    logic [WIDTH:0]    step_prem;
    logic [WIDTH-1:0]  step_quo;
    logic              unused_ax_msb;

`ifdef FA_DIVSS2_QUEUE_EN
    logic              pend_v_q, pend_v_d;
    logic [WIDTH-1:0]  pend_x_q, pend_x_d;
    logic [WIDTH-1:0]  pend_y_q, pend_y_d;
    logic              pend_cap;
`endif

    fa_divss2_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prem_i (prem_q),
        .quo_i  (quo_q),
        .dvs_i  (dvs_q),
        .prem_o (step_prem),
        .quo_o  (step_quo)
    );

    // |x| never exceeds 2^(WIDTH-1), so it fits the WIDTH-bit quotient reg.
    assign unused_ax_msb = ax[WIDTH];

    // Pick the request to launch: fresh start, or the buffered one.
    always_comb begin
        launch = 1'b0;
        lx     = x;
        ly     = y;
`ifdef FA_DIVSS2_QUEUE_EN
        pend_cap = 1'b0;
        if (state_q == FIX && pend_v_q) begin
            launch = 1'b1;
            lx     = pend_x_q;
            ly     = pend_y_q;
        end else if (start && !pend_v_q) begin
            if (state_q == CALC) pend_cap = 1'b1;
            else                 launch   = 1'b1;
        end
`else
        launch = start && (state_q == IDLE);
`endif
    end

    // Operand magnitudes on WIDTH+1 bits so that -2^(WIDTH-1) is exact.
    always_comb begin
        lx_ext = {lx[WIDTH-1], lx};
        ly_ext = {ly[WIDTH-1], ly};
        ax     = lx[WIDTH-1] ? -lx_ext : lx_ext;
        ay     = ly[WIDTH-1] ? -ly_ext : ly_ext;
    end

    // Next-state, datapath and result formation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        ovfp_d  = ovfp_q;
        dzp_d   = dzp_q;
        res_d   = res_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            CALC: begin
                prem_d = step_prem;
                quo_d  = step_quo;
                cnt_d  = cnt_q + LCNT_W'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                unique case (1'b1)
                    dzp_q: begin
                        res_d = '0;
                        rem_d = sgnr_q ? -quo_q : quo_q;
                        ovf_d = 1'b0;
                        dz_d  = 1'b1;
                    end
                    ovfp_q: begin
                        res_d = MINV;
                        rem_d = '0;
                        ovf_d = 1'b1;
                        dz_d  = 1'b0;
                    end
                    default: begin
                        res_d = sgnq_q ? -quo_q : quo_q;
                        rem_d = sgnr_q ? -prem_q[WIDTH-1:0]
                                       : prem_q[WIDTH-1:0];
                        ovf_d = 1'b0;
                        dz_d  = 1'b0;
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A zero divisor skips the iterations; FIX rebuilds x from |x|.
        if (launch) begin
            prem_d  = '0;
            cnt_d   = '0;
            quo_d   = ax[WIDTH-1:0];
            dvs_d   = ay;
            sgnq_d  = lx[WIDTH-1] ^ ly[WIDTH-1];
            sgnr_d  = lx[WIDTH-1];
            ovfp_d  = (lx == MINV) && (ly == ONES);
            dzp_d   = (ly == '0);
            state_d = (ly == '0) ? FIX : CALC;
        end
    end

    // Control, datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            ovfp_q  <= 1'b0;
            dzp_q   <= 1'b0;
            res_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            ovfp_q  <= ovfp_d;
            dzp_q   <= dzp_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

`ifdef FA_DIVSS2_QUEUE_EN
    // Pending slot: filled while busy, drained as FIX completes.
    always_comb begin
        pend_v_d = pend_v_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        if (state_q == FIX && pend_v_q) pend_v_d = 1'b0;
        if (pend_cap) begin
            pend_v_d = 1'b1;
            pend_x_d = x;
            pend_y_d = y;
        end
    end

    // Pending request storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
        end else begin
            pend_v_q <= pend_v_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
        end
    end

    assign ready = !pend_v_q;
`else
    assign ready = (state_q == IDLE);
`endif

    assign done = done_q;
    assign res  = res_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_fa_divss2.sv
// Scoreboard bench for fa_divss2 at WIDTH=4 (base build).
// Expected results come from integer division in a reference model.
module tb_fa_divss2;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         ovf;
        logic         dz;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ready;
    logic         done;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dz;

    exp_t sbq[$];
    int   tests;
    int   fails;
    int   cyc;

    fa_divss2 #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .ready (ready),
        .done  (done),
        .res   (res),
        .rem   (rem),
        .ovf   (ovf),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: signed integer division, truncating toward zero.
    function automatic exp_t model(input logic [W-1:0] xa,
                                   input logic [W-1:0] ya);
        exp_t e;
        int   xi;
        int   yi;
        xi = int'($signed(xa));
        yi = int'($signed(ya));
        e.cyc = 0;
        if (yi == 0) begin
            e.res = '0;
            e.rem = xa;
            e.ovf = 1'b0;
            e.dz  = 1'b1;
        end else if (xi == -(1 << (W-1)) && yi == -1) begin
            e.res = W'(xi);
            e.rem = '0;
            e.ovf = 1'b1;
            e.dz  = 1'b0;
        end else begin
            e.res = W'(xi / yi);
            e.rem = W'(xi % yi);
            e.ovf = 1'b0;
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    // Present a request and hold start until it is accepted.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] ya);
        exp_t e;
        int   n;
        @(negedge clk);
        start = 1'b1;
        x     = xa;
        y     = ya;
        n     = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
            start = 1'b0;
            return;
        end
        e     = model(xa, ya);
        e.cyc = cyc + 1 + ((ya == '0) ? 1 : W + 1);
        sbq.push_back(e);
    endtask

    // Drop start and scramble operands to show they are not re-sampled.
    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            x     = W'($urandom);
            y     = W'($urandom);
        end
    endtask

    // Monitor: each done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 expected 0");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("res", int'(res), int'(e.res));
                chk("rem", int'(rem), int'(e.rem));
                chk("ovf", int'(ovf), int'(e.ovf));
                chk("dz", int'(dz), int'(e.dz));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        int n;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_res", int'(res), 0);
        chk("rst_rem", int'(rem), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_dz", int'(dz), 0);
        rst_n = 1'b1;

        issue(4'd7, 4'd2);    gap(2);
        issue(4'b1001, 4'd2); gap(1);
        issue(4'd7, 4'b1110); gap(1);
        issue(4'b1010, 4'b1101); gap(1);
        issue(4'b1000, 4'b1111); gap(1);
        issue(4'd5, 4'd0);    gap(1);
        issue(4'd6, 4'd3);    gap(1);
        issue(4'd7, 4'd2);
        issue(4'b1000, 4'd3); gap(1);

        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end

        // Reset two cycles into an operation: no result may appear.
        @(negedge clk);
        start = 1'b1;
        x     = 4'd7;
        y     = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(ready), 1);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_res", int'(res), 0);
        chk("mid_rst_rem", int'(rem), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        chk("mid_rst_dz", int'(dz), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            int           g;
            rx = W'($urandom);
            ry = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rx = 4'b1000;
                ry = 4'b1111;
            end
            issue(rx, ry);
            g = $urandom_range(0, 3);
            if (g != 0) gap(g);
        end
        gap(1);

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (sbq.size() != 0) begin
            void'(sbq.pop_front());
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected one");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
